led_status_arbiter: RTL
=======================

Name: led_status_arbiter

Overview:
- Shares the board's single status LED between N_REQ status requesters; each requester supplies an 8-bit blink pattern.
- A fixed-priority arbiter picks one requester and plays its pattern one bit per tick. It re-arbitrates only at frame boundaries so the LED never shows a partial pattern.
- Sits between system status sources (link up, error, activity, heartbeat) and the LED pin, alongside the existing LED driver logic.

Parameters:
- N_REQ, 4, number of requesters; index 0 has the highest priority.
- PATTERN_LEN, 8, bits per blink frame; fixed by the package constant.
- TICK_DIV, 6600000, in_clk cycles per pattern bit (100 ms at 66 MHz); must be >= 2.
- CNT_W, 23, width of the prescaler counter; must satisfy 2^CNT_W > TICK_DIV.

Ports:
- in_clk  input  1  system clock, 66 MHz.
- in_rst  input  1  synchronous, active-high reset.
- in_enable  input  1  global LED enable; when low the LED is forced off.
- in_req  input  N_REQ  per-requester request level.
- in_pattern  input  N_REQ*8  pattern of requester i at bits [8i+7:8i]; bit 0 plays first; 1 = LED on.
- out_led  output  1  registered LED drive.
- out_grant  output  N_REQ  one-hot index of the requester being played; 0 when idle.
- out_busy  output  1  high while a frame is playing.

Behaviour:
- Reset: out_led=0, out_grant=0, out_busy=0, state=IDLE, prescaler=0, bit index=0. Reset takes priority over every other event, including mid-frame.
- States: IDLE and PLAY.
- IDLE:
  - out_led=0, out_grant=0, out_busy=0.
  - If in_enable=1 and in_req!=0 at cycle t, select the lowest set index k and latch in_pattern[k] into a shadow register.
  - At t+1: state=PLAY, grant=onehot(k), busy=1, bit index=0, prescaler=0, out_led=pattern[0].
- PLAY:
  - out_led = shadow[bit index] at all times.
  - Prescaler counts 0..TICK_DIV-1. The tick fires when it equals TICK_DIV-1; the prescaler then wraps to 0 and the bit index increments.
  - Each bit is held for exactly TICK_DIV cycles; a frame lasts PATTERN_LEN*TICK_DIV cycles.
- Frame end (tick while bit index = PATTERN_LEN-1):
  - Re-arbitrate on the same cycle using the current in_req and in_enable.
  - If a request is present, the next frame starts on the next cycle with no gap: new grant, new latched pattern, index 0, prescaler 0. The same requester may be re-granted back-to-back.
  - If no request is present, go to IDLE; LED off on the next cycle.
- Pattern latching: the pattern is latched only at frame start. Changes to in_pattern mid-frame have no effect until the next frame.
- Request drop: if the granted requester drops in_req mid-frame, the frame still completes.
- Higher-priority request mid-frame: waits for the frame boundary; there is no preemption.
- in_enable low in any state: on the next cycle state=IDLE, out_led=0, out_grant=0, out_busy=0, prescaler=0. Arbitration resumes on the first cycle in_enable is high again.
- Pattern 8'h00 is played as a dark frame and still occupies a full frame time.
- Latency: request to LED update is 1 cycle from IDLE; from PLAY, up to one frame plus 1 cycle.

Decomposition:
- Package led_pkg holds:
  - PATTERN_LEN = 8.
  - State encoding: IDLE=1'b0, PLAY=1'b1.
  - A priority-encode function (lowest set bit to index, plus valid flag).
- Sub-module led_tick_gen holds the prescaler:
  - Inputs: in_clk, in_rst, in_clear.
  - Output: out_tick, a one-cycle pulse every TICK_DIV cycles after the last clear.
  - The arbiter asserts in_clear at frame start and when in_enable is low.

Test Plan:
All scenarios use TICK_DIV=4 and N_REQ=4.
1. Reset held 3 cycles, then in_enable=1 with no requests. Required: out_led=0, out_grant=0, out_busy=0 throughout.
2. Single frame: in_req=4'b0100 and pattern[2]=8'b1010_0101, request dropped after 1 cycle. Required: one cycle later out_grant=4'b0100; out_led follows 1,0,1,0,0,1,0,1, each value held 4 cycles; IDLE at cycle 33 after the request.
3. Priority at boundary: req[3] is playing; assert req[0] at frame cycle 10. Required: the req[3] frame completes all 32 cycles, then out_grant=4'b0001 on the next cycle with no gap.
4. Pattern latching: change pattern[1] from 8'hFF to 8'h00 mid-frame while req[1] is held. Required: the current frame stays lit for all 32 cycles; the next frame is dark and grant stays 4'b0010.
5. Enable drop: drop in_enable at frame cycle 13. Required: out_led=0 and out_grant=0 on the next cycle. On re-enable with req[1] held, a new frame starts at bit 0.
6. Reset mid-frame: pulse in_rst at frame cycle 20. Required: all outputs 0 on the next cycle; with req[0] held, play restarts from bit 0 one cycle after in_rst deasserts.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the status LED arbiter.
// Holds frame length, state encoding and the fixed-priority encoder.
package led_pkg;

  localparam int unsigned PATTERN_LEN = 8;
  localparam int unsigned IDX_W       = $clog2(PATTERN_LEN);
  localparam int unsigned MAX_REQ     = 32;
  localparam int unsigned REQ_IDX_W   = 5;

  typedef enum logic {
    StIdle = 1'b0,
    StPlay = 1'b1
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [REQ_IDX_W-1:0] idx;
  } prio_t;

  // Lowest set bit wins; the descending loop leaves the lowest index last.
  function automatic prio_t prio_encode(input logic [MAX_REQ-1:0] req);
    prio_t res;
    res.valid = 1'b0;
    res.idx   = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        res.valid = 1'b1;
        res.idx   = REQ_IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Bit-rate prescaler: one-cycle tick every TICK_DIV cycles after the last clear.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 6600000,
  parameter int unsigned CNT_W    = 23
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_clear,
  output logic out_tick
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign out_tick = (r_cnt == CntLast);

  always_ff @(posedge in_clk) begin
    if (in_rst || in_clear || out_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_status_arbiter.sv
// Fixed-priority sharing of one status LED; a granted pattern always plays as a
// whole frame and arbitration happens only from idle or at the frame boundary.
module led_status_arbiter
  import led_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TICK_DIV = 6600000,
  parameter int unsigned CNT_W    = 23
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic                         in_enable,
  input  logic [N_REQ-1:0]             in_req,
  input  logic [N_REQ*PATTERN_LEN-1:0] in_pattern,
  output logic                         out_led,
  output logic [N_REQ-1:0]             out_grant,
  output logic                         out_busy
);

  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(PATTERN_LEN - 1);

  state_t                 r_state;
  logic [PATTERN_LEN-1:0] r_shadow;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_led;
  logic [N_REQ-1:0]       r_grant;
  logic                   r_busy;

  logic [MAX_REQ-1:0]     w_req_ext;
  prio_t                  w_prio;
  logic [PATTERN_LEN-1:0] w_pat;
  logic [N_REQ-1:0]       w_grant_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   w_tick;
  logic                   w_frame_end;
  logic                   w_start;
  logic                   w_clear;

  assign w_req_ext = MAX_REQ'(in_req);
  assign w_prio    = prio_encode(w_req_ext);
  assign w_idx_nxt = r_idx + IDX_W'(1);

  always_comb begin
    w_pat       = '0;
    w_grant_nxt = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_prio.valid && w_prio.idx == REQ_IDX_W'(i)) begin
        w_pat          = in_pattern[i*PATTERN_LEN +: PATTERN_LEN];
        w_grant_nxt[i] = 1'b1;
      end
    end
  end

  assign w_frame_end = (r_state == StPlay) && w_tick && (r_idx == IdxLast);
  assign w_start     = in_enable && w_prio.valid && ((r_state == StIdle) || w_frame_end);
  // Prescaler stays parked at zero while idle or disabled so a frame starts aligned.
  assign w_clear     = !in_enable || (r_state == StIdle) || w_start;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_clear (w_clear),
    .out_tick (w_tick)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst || !in_enable) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_led    <= 1'b0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      if (in_rst) begin
        r_shadow <= '0;
      end
    end else if (w_start) begin
      r_state  <= StPlay;
      r_shadow <= w_pat;
      r_idx    <= '0;
      r_led    <= w_pat[0];
      r_grant  <= w_grant_nxt;
      r_busy   <= 1'b1;
    end else if (w_frame_end) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_led   <= 1'b0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else if (r_state == StPlay && w_tick) begin
      r_idx <= w_idx_nxt;
      r_led <= r_shadow[w_idx_nxt];
    end
  end

  assign out_led   = r_led;
  assign out_grant = r_grant;
  assign out_busy  = r_busy;

endmodule
